// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns / bypass engine.
// A 128-bit block is captured on accept. COLS_PER_CYCLE columns are then
// transformed per RUN cycle into a result register. The result is held
// until downstream takes it.
module mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_mode,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int unsigned NUM_STEPS = 4 / COLS_PER_CYCLE;
  localparam logic [1:0]  LAST_CNT  = 2'(NUM_STEPS - 1);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [1:0]   mode_q, mode_d;
  logic [127:0] in_q, in_d;
  logic [127:0] res_q, res_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // One column unit. Mode 00 is forward, 01 is inverse, and 1x is bypass.
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic [1:0] m);
    logic [7:0] b  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] o  [4];
    logic [1:0] r0, r1, r2, r3;
    b[0] = c[31:24];
    b[1] = c[23:16];
    b[2] = c[15:8];
    b[3] = c[7:0];
    for (int unsigned r = 0; r < 4; r++) begin
      r0     = 2'(r);
      x2[r0] = xtime(b[r0]);
      x4[r0] = xtime(x2[r0]);
      x8[r0] = xtime(x4[r0]);
    end
    for (int unsigned r = 0; r < 4; r++) begin
      // 2-bit indices wrap naturally, giving the mod-4 row rotation.
      r0 = 2'(r);
      r1 = r0 + 2'd1;
      r2 = r0 + 2'd2;
      r3 = r0 + 2'd3;
      case (m)
        2'b00:   o[r0] = x2[r0] ^ (x2[r1] ^ b[r1]) ^ b[r2] ^ b[r3];
        2'b01:   o[r0] = (x8[r0] ^ x4[r0] ^ x2[r0])   // 0E
                       ^ (x8[r1] ^ x2[r1] ^ b[r1])    // 0B
                       ^ (x8[r2] ^ x4[r2] ^ b[r2])    // 0D
                       ^ (x8[r3] ^ b[r3]);            // 09
        default: o[r0] = b[r0];
      endcase
    end
    return {o[0], o[1], o[2], o[3]};
  endfunction

  // Next-state logic: handshakes, the column counter, and the transform of the current column group.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    in_d    = in_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_d    = in_state;
          mode_d  = in_mode;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
          logic [1:0] col;
          logic [6:0] lsb;
          col = 2'(32'(cnt_q) * COLS_PER_CYCLE + j);
          // Column 0 occupies the most significant 32 bits.
          lsb = {2'd3 - col, 5'd0};
          res_d[lsb +: 32] = mix_col(in_q[lsb +: 32], mode_q);
        end
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      in_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      in_q    <= in_d;
      res_q   <= res_d;
    end
  end

  // Handshake outputs are decoded from the state register only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_state = res_q;
    if (state_q == IDLE) in_ready  = 1'b1;
    if (state_q == DONE) out_valid = 1'b1;
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq. It has three instances, with
// COLS_PER_CYCLE = 1, 4 and 2.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [1:0]   in_mode   [3];
  logic [127:0] in_state  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] sb [$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int unsigned CPC = (gi == 0) ? 1 : (gi == 1) ? 4 : 2;
    mix_columns_seq #(.COLS_PER_CYCLE(CPC)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .in_mode   (in_mode[gi]),
      .in_state  (in_state[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi]),
      .out_state (out_state[gi])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1B;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] st, input logic [1:0] mode);
    logic [7:0]   ib [16];
    logic [7:0]   coef [4];
    logic [127:0] tmp;
    logic [127:0] res = '0;
    logic [7:0]   o;
    if (mode[1]) return st;
    for (int k = 0; k < 16; k++) begin
      tmp   = st << (8 * k);
      ib[k] = tmp[127:120];
    end
    if (mode == 2'b00) begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end else begin
      coef[0] = 8'h0E; coef[1] = 8'h0B; coef[2] = 8'h0D; coef[3] = 8'h09;
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o = 8'h00;
        for (int k = 0; k < 4; k++) o = o ^ gmul(coef[k], ib[c * 4 + (r + k) % 4]);
        res = {res[119:0], o};
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int steps(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 2;
  endfunction

  // Output monitor: every completed output handshake is checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 3; d++) begin
        if (out_valid[d] && out_ready[d]) begin
          if (sb.size() == 0) begin
            check("unexpected_out", out_state[d], '0);
            if (out_state[d] == '0) begin
              n_errors++;
              $display("FAIL unexpected_out: dut %0d produced output with empty scoreboard", d);
            end
          end else begin
            check("out_state", out_state[d], sb.pop_front());
          end
        end
      end
    end
  end

  // Present one block and hold in_valid until it is accepted. Returns just after the accept edge.
  task automatic send(input int d, input logic [1:0] mode, input logic [127:0] st,
                      input logic [127:0] exp);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_valid[d] = 1'b1;
    in_mode[d]  = mode;
    in_state[d] = st;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready[d]) begin ok = 1'b1; break; end
    end
    check("accept", 128'(ok), 128'(1));
    if (ok) begin
      @(posedge clk);
      sb.push_back(exp);
    end
    #1;
    in_valid[d] = 1'b0;
    in_mode[d]  = 2'($urandom);
    in_state[d] = rnd128();
  endtask

  // Count edges from the accept edge until out_valid is seen.
  task automatic check_latency(input int d);
    int lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid[d]) break;
    end
    check("latency", 128'(lat), 128'(steps(d)));
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 128'(sb.size()), 128'(0));
  endtask

  task automatic wait_valid(input int d);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid[d]) begin seen = 1'b1; break; end
    end
    check("wait_valid", 128'(seen), 128'(1));
  endtask

  task automatic stream(input int d, input int nblk);
    bit done = 1'b0;
    fork
      begin
        logic [1:0]   m;
        logic [127:0] s;
        for (int n = 0; n < nblk; n++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          m = 2'($urandom_range(0, 3));
          s = rnd128();
          send(d, m, s, model(s, m));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready[d] = ($urandom_range(0, 2) != 0);
        end
        out_ready[d] = 1'b1;
      end
    join
    drain();
  endtask

  initial begin
    logic [127:0] s;
    logic [127:0] e;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_mode[d]   = 2'b00;
      in_state[d]  = '0;
      out_ready[d] = 1'b1;
    end
    #3;
    for (int d = 0; d < 3; d++) begin
      check("rst_in_ready", 128'(in_ready[d]), 128'(1));
      check("rst_out_valid", 128'(out_valid[d]), 128'(0));
      check("rst_out_state", out_state[d], '0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Forward on C=1, with the column test vector.
    send(0, 2'b00, 128'hdb135345_f20a225c_01010101_c6c6c6c6,
                   128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    check_latency(0);
    drain();

    // Inverse on C=4.
    send(1, 2'b01, 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8,
                   128'hdb135345_f20a225c_d4d4d4d5_2d26314c);
    check_latency(1);
    drain();

    // Bypass on C=2, using mode 11.
    s = rnd128();
    send(2, 2'b11, s, s);
    check_latency(2);
    drain();

    // Backpressure on C=1. Stray in_valid pulses while in DONE must be ignored.
    out_ready[0] = 1'b0;
    s = rnd128();
    e = model(s, 2'b00);
    send(0, 2'b00, s, e);
    wait_valid(0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid[0] = 1'($urandom);
      in_mode[0]  = 2'($urandom);
      in_state[0] = rnd128();
      @(negedge clk);
      check("bp_out_state", out_state[0], e);
      check("bp_in_ready", 128'(in_ready[0]), 128'(0));
      check("bp_out_valid", 128'(out_valid[0]), 128'(1));
    end
    @(posedge clk); #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_mode[0]   = 2'b01;
    in_state[0]  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    @(negedge clk);
    check("bp_idle_in_ready", 128'(in_ready[0]), 128'(1));
    check("bp_idle_out_valid", 128'(out_valid[0]), 128'(0));
    @(posedge clk);
    sb.push_back(128'hdb135345_f20a225c_d4d4d4d5_2d26314c);
    #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("bp_accepted", 128'(in_ready[0]), 128'(0));
    out_ready[0] = 1'b1;
    drain();

    // Reset during RUN on C=1, after two RUN edges (cnt=2).
    send(0, 2'b00, rnd128(), '0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check("mid_rst_out_valid", 128'(out_valid[0]), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready[0]), 128'(1));
    check("mid_rst_out_state", out_state[0], '0);
    @(negedge clk);
    rst_n = 1'b1;
    s = rnd128();
    send(0, 2'b01, s, model(s, 2'b01));
    check_latency(0);
    drain();

    // Random streams with input and output gaps.
    stream(0, 100);
    stream(1, 30);
    stream(2, 30);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
